// File: rtl/wide_add_pkg.sv
// Shared constants, state encoding and sizing helper for the wide-operand
// add/subtract sequencer.
package wide_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-slice build still needs a 1-bit index register.
  function automatic int slice_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/CarrySelectAdder.sv
// 16-bit carry-select adder: the low byte ripples and the high byte is
// precomputed for both carry-ins, then picked by the low byte's carry-out.
module CarrySelectAdder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  assign lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
  assign hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign hi1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

  assign sum  = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
  assign cout = lo[8] ? hi1[8] : hi0[8];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor that walks the operands through one
// 16-bit CarrySelectAdder, LSB slice first, with a registered carry chain.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = slice_idx_w(NSLICE);

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               last;

  assign last = (idx == IDX_W'(NSLICE - 1));

  CarrySelectAdder u_csa (
    .a    (op_a[SLICE_W*idx +: SLICE_W]),
    .b    (op_b[SLICE_W*idx +: SLICE_W]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, so B is inverted once at acceptance and the
  // carry chain is seeded with 1; overflow therefore uses the inverted B's MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[SLICE_W*idx +: SLICE_W] <= slice_sum;
          carry <= slice_cout;
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            cout     <= slice_cout;
            overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                        (slice_sum[SLICE_W-1] != op_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and randomised checks of wide_add_sequencer at WIDTH=64 against a
// full-width arithmetic reference.
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        overflow;

  int total  = 0;
  int passed = 0;

  wide_add_sequencer #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
  endtask

  // Returns {overflow, cout, sum} computed on full-width integers.
  function automatic logic [65:0] refModel(input logic [63:0] ta, input logic [63:0] tb,
                                           input logic tcin, input logic tsub);
    logic [63:0] eb;
    logic [64:0] full;
    logic        ovf;
    eb   = tsub ? ~tb : tb;
    full = {1'b0, ta} + {1'b0, eb} + {64'd0, (tsub ? 1'b1 : tcin)};
    ovf  = (ta[63] == eb[63]) && (full[63] != ta[63]);
    return {ovf, full[64], full[63:0]};
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
  task automatic sendRequest(input logic [63:0] ta, input logic [63:0] tb,
                             input logic tcin, input logic tsub);
    int waits;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    checkOutput("accept_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = {$urandom, $urandom}; cin = ~tcin; sub = ~tsub;
  endtask

  task automatic collectResult(input string tag, input logic [65:0] exp, input int hold);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd4);
    checkOutput({tag, "_sum"}, sum, exp[63:0]);
    checkOutput({tag, "_cout"}, {63'd0, cout}, {63'd0, exp[64]});
    checkOutput({tag, "_ovf"}, {63'd0, overflow}, {63'd0, exp[65]});
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
      end
      checkOutput({tag, "_hold"}, {in_ready, out_valid, overflow, cout, sum[59:0]},
                  {1'b0, 1'b1, exp[65], exp[64], exp[59:0]});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                               input logic tcin, input logic tsub, input logic [65:0] exp,
                               input int gap, input int hold);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    sendRequest(ta, tb, tcin, tsub);
    collectResult(tag, exp, hold);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic        rs;
    logic [63:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", {59'd0, in_ready, out_valid, cout, overflow, |sum},
                {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("ripple", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
                  {1'b0, 1'b0, 64'h0000_0000_0001_0000}, 0, 0);
    applyStimulus("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
                  {1'b0, 1'b1, 64'h0}, 1, 0);
    applyStimulus("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1,
                  {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 0, 0);
    applyStimulus("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                  {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF}, 2, 0);
    applyStimulus("cin_ignored_sub", 64'd10, 64'd3, 1'b1, 1'b1,
                  {1'b0, 1'b1, 64'd7}, 0, 0);

    // Back-pressure: result held 10 cycles while a second request waits.
    sendRequest(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("bp_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("bp_sum", sum, 64'h2345_6789_ABCD_F001);
    held = sum;
    a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_stable", {in_ready, out_valid, sum[61:0]}, {1'b0, 1'b1, held[61:0]});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_release", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0;
    checkOutput("bp_second_accept", {63'd0, in_ready}, 64'd0);
    collectResult("bp_second", {1'b1, 1'b0, 64'h8000_0000_0000_0000}, 0);

    // Reset during the second RUN cycle drops the transaction.
    sendRequest(64'h1111_2222_3333_4444, 64'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midrun_reset", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    checkOutput("midrun_reset_sum", sum, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus("after_reset", 64'd1, 64'd2, 1'b0, 1'b0, {1'b0, 1'b0, 64'd3}, 0, 0);

    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (n % 8 == 0) rb = ~ra;
      applyStimulus("random", ra, rb, rc, rs, refModel(ra, rb, rc, rs),
                    $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
